spi_boot_loader: RTL and testbench
==================================

Name: spi_boot_loader

Overview:
- Sequences the byte-level SPI master engine at power-up: issues a flash READ (03h) and streams LENGTH bytes into a memory write port.
- The CPU is held off while this runs; afterwards the SPI engine is handed to the CPU port interface (E7h/EBh) unchanged.
- Sits between the CPU-side SPI port logic and the SPI byte engine, with a write path to ROM/SDRAM.

Parameters:
- FLASH_ADDR, 24'h000000, flash start byte address sent after the command byte.
- LENGTH, 16384, bytes to copy; legal range 0..2**ADDR_W.
- ADDR_W, 14, memory address width.
- GUARD, 4, ce-qualified cycles CS stays high before the command.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ce  in  1  clock enable; all state advances only when ce=1
- spiStart  out  1  one-ce-cycle pulse that starts an engine byte
- spiTx  out  8  byte to shift out, valid with spiStart
- spiCs  out  1  flash chip select, active low
- spiRx  in  8  received byte, valid while spiBusy=0 after a transfer
- spiBusy  in  1  engine shifting; rises the ce-cycle after spiStart
- cpuStart  in  1  CPU-side start pulse
- cpuTx  in  8  CPU-side transmit byte
- cpuCs  in  1  CPU-side chip select
- cpuRx  out  8  received byte to CPU port
- memA  out  ADDR_W  write address
- memD  out  8  write data
- memWr  out  1  write request, held until accepted
- memReady  in  1  memory accepts write when memWr=1 and memReady=1 on a ce cycle
- done  out  1  boot complete; CPU reset release

Behaviour:
- Reset values (async, reset=0):
  - state=GUARDW, spiCs=1, spiStart=0, spiTx=00h, memWr=0, memA=0, memD=00h, done=0, counters=0.
- States: GUARDW, CMD, ADR2, ADR1, ADR0, DATA, WRITE, FINISH, PASS.
- GUARDW:
  - spiCs=1 for GUARD ce-cycles.
  - Then, if LENGTH=0, go to FINISH; else drop spiCs=0 and go to CMD.
- Byte transfer (CMD, ADRx, DATA):
  1. Pulse spiStart for one ce-cycle with spiTx loaded.
  2. Ignore spiBusy during the next ce-cycle.
  3. Wait for spiBusy=0; the transfer is then complete.
- Byte values:
  - CMD sends 03h.
  - ADR2/ADR1/ADR0 send FLASH_ADDR[23:16], [15:8], [7:0].
  - DATA sends FFh.
- DATA complete: capture spiRx into memD, assert memWr, go to WRITE.
- WRITE:
  - Hold memA, memD and memWr=1 until memReady=1 on a ce cycle; deassert memWr that cycle.
  - Increment the byte count and memA.
  - If count==LENGTH go to FINISH, else go to DATA.
- memA width and wrap:
  - Wraps modulo 2**ADDR_W.
  - The count register is ADDR_W+1 bits, so LENGTH=2**ADDR_W is exact: last memA = all ones, then memA wraps to 0.
- FINISH: spiCs=1 and done=1, then go to PASS on the next ce-cycle. done stays 1 until reset.
- PASS, combinational mux: spiStart=cpuStart, spiTx=cpuTx, spiCs=cpuCs; memWr stays 0.
- cpuRx=spiRx in every state.
- CPU inputs are ignored before PASS. There is no queueing, so a CPU start before done is lost.
- Reset mid-operation:
  - Immediate return to reset values; spiCs=1 aborts the flash read.
  - After reset release the full sequence restarts from GUARDW.
- ce=0 freezes all registers. A spiStart pulse spans exactly one ce=1 cycle.
- Latency to first memWr: GUARD + 5 engine transfers + 5 ce-cycles of controller overhead (4 address/cmd issues, 1 data issue).

Test Plan:
- LENGTH=4, FLASH_ADDR=123456h, memReady tied 1, flash model returns A0,A1,A2,A3 -> spiTx sequence 03,12,34,56,FF×4; writes (0,A0),(1,A1),(2,A2),(3,A3); spiCs rises; done=1.
- memReady held 0 for 7 ce-cycles on byte 2 -> memWr, memA=2 and memD stay stable for 7 cycles; no 5th spiStart until accepted; final data intact.
- ADR_W=2, LENGTH=4 -> memA 0,1,2,3, then register wraps to 0; exactly 4 writes; done=1.
- LENGTH=0 -> spiCs never low, no spiStart, no memWr; done=1 after GUARD+1 ce-cycles.
- Assert reset during ADR1 -> spiCs=1, done=0, memWr=0 immediately (asynchronous); after release the sequence restarts with 03h.
- After done, cpuCs=0, cpuStart pulse, cpuTx=5Ah -> spiStart pulses, spiTx=5Ah, spiCs=0; cpuStart pulse before done -> no spiStart.

Source files
------------

// File: rtl/spi_boot_loader.sv
// Boot loader: drives the SPI byte engine through a flash READ (03h) and copies LENGTH bytes to memory.
// Latency: GUARD + 5 engine transfers + controller issue/hold cycles to the first memWr.
// Backpressure: memWr/memA/memD are held until memReady on a ce cycle; no further SPI byte is issued meanwhile.
//
// Ports:
//   clock, reset(async, active low), ce (clock enable for all state)
//   spiStart/spiTx/spiCs -> SPI byte engine; spiRx/spiBusy <- engine
//   cpuStart/cpuTx/cpuCs/cpuRx : CPU-side port, connected through to the engine once boot is complete
//   memA/memD/memWr/memReady   : memory write port
//   done : boot complete, releases the CPU from reset
module spi_boot_loader #(
  parameter logic [23:0] FLASH_ADDR = 24'h000000,
  parameter int          LENGTH     = 16384,
  parameter int          ADDR_W     = 14,
  parameter int          GUARD      = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ce,
  output logic              spiStart,
  output logic [7:0]        spiTx,
  output logic              spiCs,
  input  logic [7:0]        spiRx,
  input  logic              spiBusy,
  input  logic              cpuStart,
  input  logic [7:0]        cpuTx,
  input  logic              cpuCs,
  output logic [7:0]        cpuRx,
  output logic [ADDR_W-1:0] memA,
  output logic [7:0]        memD,
  output logic              memWr,
  input  logic              memReady,
  output logic              done
);

  localparam logic [3:0] GUARDW = 4'd0;
  localparam logic [3:0] CMD    = 4'd1;
  localparam logic [3:0] ADR2   = 4'd2;
  localparam logic [3:0] ADR1   = 4'd3;
  localparam logic [3:0] ADR0   = 4'd4;
  localparam logic [3:0] DATA   = 4'd5;
  localparam logic [3:0] WRITE  = 4'd6;
  localparam logic [3:0] FINISH = 4'd7;
  localparam logic [3:0] PASS   = 4'd8;

  // Sub-phases of one engine byte: issue the pulse, hold it for one ce cycle
  // (engine busy is not yet valid), then wait for busy to fall.
  localparam logic [1:0] PH_ISSUE = 2'd0;
  localparam logic [1:0] PH_HOLD  = 2'd1;
  localparam logic [1:0] PH_WAIT  = 2'd2;

  // Byte counter is one bit wider than the address so LENGTH = 2**ADDR_W is representable.
  localparam int               CW      = ADDR_W + 1;
  localparam logic [CW-1:0]    LEN_C   = CW'(LENGTH);
  localparam int               GW      = $clog2(GUARD + 1) + 1;
  localparam logic [31:0]      GUARD_C = 32'(GUARD);

  logic [3:0]        state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        dat_q, dat_d;
  logic [7:0]        tx_q, tx_d;
  logic              start_q, start_d;
  logic              cs_q, cs_d;
  logic              wr_q, wr_d;
  logic              done_q, done_d;
  logic [7:0]        byte_tx;
  logic              pass;

  always_comb begin
    byte_tx = 8'hFF;
    case (state_q)
      CMD:     byte_tx = 8'h03;
      ADR2:    byte_tx = FLASH_ADDR[23:16];
      ADR1:    byte_tx = FLASH_ADDR[15:8];
      ADR0:    byte_tx = FLASH_ADDR[7:0];
      default: byte_tx = 8'hFF;
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    gcnt_d  = gcnt_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dat_d   = dat_q;
    tx_d    = tx_q;
    start_d = start_q;
    cs_d    = cs_q;
    wr_d    = wr_q;
    done_d  = done_q;

    case (state_q)
      GUARDW: begin
        if (({{(32-GW){1'b0}}, gcnt_q} + 32'd1) >= GUARD_C) begin
          if (LENGTH == 0) begin
            state_d = FINISH;
          end else begin
            cs_d    = 1'b0;
            phase_d = PH_ISSUE;
            state_d = CMD;
          end
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end

      CMD, ADR2, ADR1, ADR0, DATA: begin
        case (phase_q)
          PH_ISSUE: begin
            start_d = 1'b1;
            tx_d    = byte_tx;
            phase_d = PH_HOLD;
          end
          PH_HOLD: begin
            start_d = 1'b0;
            phase_d = PH_WAIT;
          end
          default: begin
            if (!spiBusy) begin
              phase_d = PH_ISSUE;
              case (state_q)
                CMD:     state_d = ADR2;
                ADR2:    state_d = ADR1;
                ADR1:    state_d = ADR0;
                ADR0:    state_d = DATA;
                default: begin
                  dat_d   = spiRx;
                  wr_d    = 1'b1;
                  state_d = WRITE;
                end
              endcase
            end
          end
        endcase
      end

      WRITE: begin
        if (memReady) begin
          wr_d   = 1'b0;
          cnt_d  = cnt_q + CW'(1);
          addr_d = addr_q + ADDR_W'(1);
          if ((cnt_q + CW'(1)) == LEN_C) begin
            cs_d    = 1'b1;
            state_d = FINISH;
          end else begin
            phase_d = PH_ISSUE;
            state_d = DATA;
          end
        end
      end

      FINISH: begin
        cs_d    = 1'b1;
        done_d  = 1'b1;
        state_d = PASS;
      end

      PASS: begin
        state_d = PASS;
      end

      default: state_d = GUARDW;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= GUARDW;
      phase_q <= PH_ISSUE;
      gcnt_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      dat_q   <= 8'h00;
      tx_q    <= 8'h00;
      start_q <= 1'b0;
      cs_q    <= 1'b1;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      phase_q <= phase_d;
      gcnt_q  <= gcnt_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      tx_q    <= tx_d;
      start_q <= start_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
    end
  end

  // After boot the engine belongs to the CPU port; the mux is combinational so
  // CPU timing is unchanged. Before PASS the CPU inputs are simply ignored.
  assign pass     = (state_q == PASS);
  assign spiStart = pass ? cpuStart : start_q;
  assign spiTx    = pass ? cpuTx    : tx_q;
  assign spiCs    = pass ? cpuCs    : cs_q;
  assign cpuRx    = spiRx;
  assign memA     = addr_q;
  assign memD     = dat_q;
  assign memWr    = wr_q;
  assign done     = done_q;

endmodule

// File: tb/tb_spi_boot_loader.sv
module tb_spi_boot_loader;

  localparam int GUARD = 4;

  logic       clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       ce;
  logic       cpuStart, cpuCs;
  logic [7:0] cpuTx;
  logic       spiBusy;
  logic [7:0] spiRx;
  logic       memReady;

  logic       spiStart, spiCs, memWr, done;
  logic [7:0] spiTx, cpuRx, memD;
  logic [1:0] memA;

  logic       z_start, z_cs, z_wr, z_done;
  logic [7:0] z_tx, z_rx, z_d;
  logic [1:0] z_a;

  spi_boot_loader #(.FLASH_ADDR(24'h123456), .LENGTH(4), .ADDR_W(2), .GUARD(GUARD)) dut (
    .clock(clock), .reset(reset), .ce(ce),
    .spiStart(spiStart), .spiTx(spiTx), .spiCs(spiCs),
    .spiRx(spiRx), .spiBusy(spiBusy),
    .cpuStart(cpuStart), .cpuTx(cpuTx), .cpuCs(cpuCs), .cpuRx(cpuRx),
    .memA(memA), .memD(memD), .memWr(memWr), .memReady(memReady),
    .done(done)
  );

  spi_boot_loader #(.FLASH_ADDR(24'h000000), .LENGTH(0), .ADDR_W(2), .GUARD(GUARD)) dut_z (
    .clock(clock), .reset(reset), .ce(ce),
    .spiStart(z_start), .spiTx(z_tx), .spiCs(z_cs),
    .spiRx(8'h00), .spiBusy(1'b0),
    .cpuStart(cpuStart), .cpuTx(cpuTx), .cpuCs(cpuCs), .cpuRx(z_rx),
    .memA(z_a), .memD(z_d), .memWr(z_wr), .memReady(1'b1),
    .done(z_done)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_tx[$];
  logic [9:0] exp_wr[$];
  int         cyc = 0;
  int         idx = 0;
  int         bcnt = 0;
  logic [7:0] reply = 8'h00;
  logic [7:0] flash_base;
  bit         z_watch = 1'b0;
  bit         z_bad_cs = 1'b0, z_bad_start = 1'b0, z_bad_wr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_boot(input logic [7:0] base);
    exp_tx.push_back(8'h03);
    exp_tx.push_back(8'h12);
    exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h56);
    for (int i = 0; i < 4; i++) begin
      exp_tx.push_back(8'hFF);
      exp_wr.push_back({2'(i), base + 8'(i)});
    end
  endtask

  task automatic wait_done(input string name);
    int i;
    i = 0;
    while (!done && i < 2000) begin
      @(posedge clock); #1;
      i++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: done=%0b after %0d cycles, expected 1", name, done, i);
    end
  endtask

  // Negedge process: picks ce for the coming edge, models the SPI engine and
  // flash, and acts as the scoreboard monitor for engine starts and memory writes.
  always @(negedge clock) begin
    cyc++;
    ce = ((cyc % 5) != 3);
    if (!reset) begin
      spiBusy = 1'b0;
      spiRx   = 8'h00;
      bcnt    = 0;
      idx     = 0;
    end else begin
      if (spiCs) idx = 0;
      if (ce && spiStart) begin
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spiTx_unexpected: got start with %0h, expected no start", spiTx);
        end else begin
          check("spiTx", 32'(spiTx), 32'(exp_tx.pop_front()));
        end
        reply   = (idx >= 4) ? flash_base + 8'(idx - 4) : 8'h00;
        idx++;
        spiBusy = 1'b1;
        bcnt    = 3;
      end else if (ce && spiBusy) begin
        bcnt--;
        if (bcnt == 0) begin
          spiBusy = 1'b0;
          spiRx   = reply;
        end
      end
      if (ce && memWr && memReady) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_write_unexpected: got addr %0h data %0h, expected none", memA, memD);
        end else begin
          check("mem_write", 32'({memA, memD}), 32'(exp_wr.pop_front()));
        end
      end
      if (z_watch) begin
        if (!z_cs)   z_bad_cs    = 1'b1;
        if (z_start) z_bad_start = 1'b1;
        if (z_wr)    z_bad_wr    = 1'b1;
      end
    end
  end

  initial begin
    bit found;
    int k;
    reset      = 1'b1;
    memReady   = 1'b1;
    cpuStart   = 1'b0;
    cpuCs      = 1'b1;
    cpuTx      = 8'h00;
    flash_base = 8'hA0;
    #1 reset = 1'b0;
    #1;
    check("rst_spiCs",    32'(spiCs),    32'd1);
    check("rst_spiStart", 32'(spiStart), 32'd0);
    check("rst_spiTx",    32'(spiTx),    32'h00);
    check("rst_memWr",    32'(memWr),    32'd0);
    check("rst_memA",     32'(memA),     32'd0);
    check("rst_memD",     32'(memD),     32'h00);
    check("rst_done",     32'(done),     32'd0);

    // ---- Run 1: plain boot, LENGTH=0 instance timing alongside ----
    repeat (3) @(posedge clock);
    #1;
    push_boot(8'hA0);
    reset   = 1'b1;
    z_watch = 1'b1;
    for (int n = 1; n <= GUARD + 2; n++) begin
      k = 0;
      do begin
        @(posedge clock); #1;
        k++;
      end while (!ce && k < 20);
      check("z_done_timing", 32'(z_done), (n >= GUARD + 1) ? 32'd1 : 32'd0);
    end
    wait_done("run1_done");
    check("run1_done",   32'(done),  32'd1);
    check("run1_cs_hi",  32'(spiCs), 32'd1);
    check("run1_wrap",   32'(memA),  32'd0);
    check("run1_wr_off", 32'(memWr), 32'd0);
    check("run1_tx_left", 32'(exp_tx.size()), 32'd0);
    check("run1_wr_left", 32'(exp_wr.size()), 32'd0);

    // ---- CPU pass-through after done ----
    z_watch = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    exp_tx.push_back(8'h5A);
    cpuCs    = 1'b0;
    cpuTx    = 8'h5A;
    cpuStart = 1'b1;
    #1;
    check("pass_start", 32'(spiStart), 32'd1);
    check("pass_tx",    32'(spiTx),    32'h5A);
    check("pass_cs",    32'(spiCs),    32'd0);
    k = 0;
    do begin
      @(posedge clock); #1;
      k++;
    end while (!ce && k < 20);
    cpuStart = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    check("pass_rx", 32'(cpuRx), 32'(spiRx));
    check("pass_tx_left", 32'(exp_tx.size()), 32'd0);
    cpuCs = 1'b1;

    // ---- Run 2: early CPU start ignored, abort in ADR1, restart with stall ----
    @(posedge clock); #1;
    reset      = 1'b0;
    flash_base = 8'hC0;
    @(posedge clock); #1;
    reset = 1'b1;
    exp_tx.push_back(8'h03);
    exp_tx.push_back(8'h12);
    cpuCs    = 1'b0;
    cpuTx    = 8'h5A;
    cpuStart = 1'b1;
    #1;
    check("early_cpu_start", 32'(spiStart), 32'd0);
    check("early_cpu_cs",    32'(spiCs),    32'd1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    cpuStart = 1'b0;
    cpuCs    = 1'b1;

    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clock); #1;
      if (spiStart && spiTx == 8'h34) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL abort_wait: ADR1 byte not seen, expected 34 start");
    end
    #1 reset = 1'b0;
    #1;
    check("abort_cs",    32'(spiCs),    32'd1);
    check("abort_done",  32'(done),     32'd0);
    check("abort_wr",    32'(memWr),    32'd0);
    check("abort_start", 32'(spiStart), 32'd0);
    check("abort_tx_left", 32'(exp_tx.size()), 32'd0);
    @(posedge clock); #1;
    push_boot(8'hC0);
    reset = 1'b1;

    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clock); #1;
      if (memWr && memA == 2'd2) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL stall_wait: write of byte 2 not seen, expected memA=2");
    end
    memReady = 1'b0;
    k = 0;
    for (int i = 0; i < 200 && k < 7; i++) begin
      @(posedge clock); #1;
      if (ce) begin
        k++;
        check("stall_hold", 32'({spiStart, memWr, memA, memD}), 32'({1'b0, 1'b1, 2'd2, 8'hC2}));
      end
    end
    memReady = 1'b1;
    wait_done("run2_done");
    check("run2_done",    32'(done),  32'd1);
    check("run2_wrap",    32'(memA),  32'd0);
    check("run2_tx_left", 32'(exp_tx.size()), 32'd0);
    check("run2_wr_left", 32'(exp_wr.size()), 32'd0);

    check("z_cs_never_low", 32'(z_bad_cs),    32'd0);
    check("z_no_start",     32'(z_bad_start), 32'd0);
    check("z_no_write",     32'(z_bad_wr),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
